// File: rtl/sensor_conditioner_if.sv
// rtl/sensor_conditioner_if.sv - detector contact in, clean demand/pending/fault out
interface sensor_conditioner_if #(
   parameter int CNT_W = 4
);
   logic             sensor_raw;
   logic             ack;
   logic             sensor;
   logic [CNT_W-1:0] pending;
   logic             fault;

   modport master (
      output sensor_raw,
      output ack,
      input  sensor,
      input  pending,
      input  fault
   );

   modport slave (
      input  sensor_raw,
      input  ack,
      output sensor,
      output pending,
      output fault
   );
endinterface

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronize, debounce and latch vehicle-detector demand
// with saturating arrival count and stuck-contact fail-safe.
module sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int STUCK_CYCLES    = 64,
   parameter int CNT_W           = 4
) (
   input logic                  clk,
   input logic                  reset,
   sensor_conditioner_if.slave  bus
);
   localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]      STUCK_MAX = 16'(STUCK_CYCLES);
   localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic [7:0]       dcnt_q, dcnt_d;
   logic [15:0]      scnt_q, scnt_d;
   logic             arr_q, arr_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             sensor_q, sensor_d;
   logic             fault_q, fault_d;
   logic             ack_eff;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         dcnt_q    <= '0;
         scnt_q    <= '0;
         arr_q     <= 1'b0;
         state_q   <= S_IDLE;
         pending_q <= '0;
         sensor_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         sync1_q   <= bus.sensor_raw;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         dcnt_q    <= dcnt_d;
         scnt_q    <= scnt_d;
         arr_q     <= arr_d;
         state_q   <= state_d;
         pending_q <= pending_d;
         sensor_q  <= sensor_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      deb_d     = deb_q;
      dcnt_d    = dcnt_q;
      scnt_d    = scnt_q;
      state_d   = state_q;
      pending_d = pending_q;

      // Any cycle agreeing with the current level restarts the stability count.
      if (sync2_q == deb_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DEB_LAST) begin
         deb_d  = sync2_q;
         dcnt_d = '0;
      end else begin
         dcnt_d = dcnt_q + 8'd1;
      end

      arr_d = deb_d & ~deb_q;

      if (!deb_q) begin
         scnt_d = '0;
      end else if (scnt_q != STUCK_MAX) begin
         scnt_d = scnt_q + 16'd1;
      end
      fault_d = (scnt_d == STUCK_MAX);

      ack_eff = bus.ack && (state_q == S_REQ);

      case (state_q)
         S_IDLE: if (arr_q) state_d = S_REQ;
         S_REQ:  if (bus.ack && !arr_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A new arrival beats a coincident ack: it becomes the only pending one.
      if (arr_q && ack_eff) begin
         pending_d = PEND_ONE;
      end else if (arr_q) begin
         if (pending_q != PEND_MAX) pending_d = pending_q + PEND_ONE;
      end else if (ack_eff) begin
         pending_d = '0;
      end

      sensor_d = (state_d == S_REQ) || fault_d;
   end

   assign bus.sensor  = sensor_q;
   assign bus.pending = pending_q;
   assign bus.fault   = fault_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - directed vector table plus reset/saturation sequences
module tb_sensor_conditioner;
   logic clk = 1'b0;
   logic reset;

   sensor_conditioner_if #(.CNT_W(4)) bus ();

   sensor_conditioner #(
      .DEBOUNCE_CYCLES (8),
      .STUCK_CYCLES    (64),
      .CNT_W           (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       raw;
      logic       ack;
      int         n;
      logic       s;
      logic [3:0] p;
      logic       f;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void add(logic rst, logic raw, logic ack, int n,
                               logic s, logic [3:0] p, logic f);
      vec_t v;
      v.rst = rst; v.raw = raw; v.ack = ack; v.n = n;
      v.s = s; v.p = p; v.f = f;
      tbl.push_back(v);
   endfunction

   task automatic run(input logic rst, input logic raw, input logic ack, input int n);
      reset          = rst;
      bus.sensor_raw = raw;
      bus.ack        = ack;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect3(input string name, input logic s, input logic [3:0] p, input logic f);
      checks++;
      if (bus.sensor !== s) begin
         failures++;
         $display("FAIL %s sensor got=%b want=%b", name, bus.sensor, s);
      end
      checks++;
      if (bus.pending !== p) begin
         failures++;
         $display("FAIL %s pending got=%0d want=%0d", name, bus.pending, p);
      end
      checks++;
      if (bus.fault !== f) begin
         failures++;
         $display("FAIL %s fault got=%b want=%b", name, bus.fault, f);
      end
   endtask

   initial begin
      reset = 1'b1; bus.sensor_raw = 1'b0; bus.ack = 1'b0;
      //   rst raw ack  n    s  p  f
      add(1, 0, 0,  2,   0, 0, 0);
      add(0, 1, 0, 10,   0, 0, 0);
      add(0, 1, 0,  1,   1, 1, 0);
      add(0, 1, 0, 62,   1, 1, 0);
      add(0, 1, 0,  1,   1, 1, 1);
      add(0, 1, 1,  1,   1, 0, 1);
      add(0, 1, 0, 20,   1, 0, 1);
      add(0, 0, 0, 10,   1, 0, 1);
      add(0, 0, 0,  1,   0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         add(0, 1, 0, 5, 0, 0, 0);
         add(0, 0, 0, 3, 0, 0, 0);
      end
      add(0, 0, 0, 20,   0, 0, 0);
      add(0, 1, 0, 20,   1, 1, 0);
      add(0, 0, 0, 20,   1, 1, 0);
      add(0, 1, 0, 20,   1, 2, 0);
      add(0, 0, 0, 20,   1, 2, 0);
      add(0, 1, 0, 20,   1, 3, 0);
      add(0, 0, 0, 20,   1, 3, 0);
      add(0, 0, 1,  1,   0, 0, 0);
      add(0, 0, 0,  5,   0, 0, 0);
      add(0, 0, 1,  1,   0, 0, 0);
      add(0, 0, 0,  3,   0, 0, 0);
      add(0, 1, 0, 20,   1, 1, 0);
      add(0, 0, 0, 20,   1, 1, 0);
      add(0, 1, 0, 20,   1, 2, 0);
      add(0, 0, 0, 20,   1, 2, 0);
      add(0, 1, 0, 10,   1, 2, 0);
      add(0, 1, 1,  1,   1, 1, 0);
      add(0, 1, 0,  5,   1, 1, 0);
      add(0, 1, 1,  1,   0, 0, 0);
      add(0, 0, 0, 20,   0, 0, 0);

      foreach (tbl[i]) begin
         run(tbl[i].rst, tbl[i].raw, tbl[i].ack, tbl[i].n);
         expect3($sformatf("row%0d", i), tbl[i].s, tbl[i].p, tbl[i].f);
      end

      // Build pending=5 with a stuck fault, then reset while raw stays high.
      for (int k = 0; k < 4; k++) begin
         run(0, 1, 0, 12);
         run(0, 0, 0, 12);
      end
      run(0, 1, 0, 80);
      expect3("pre_reset", 1, 5, 1);
      run(1, 1, 1, 1);
      expect3("mid_reset", 0, 0, 0);
      run(0, 1, 0, 10);
      expect3("relatch_early", 0, 0, 0);
      run(0, 1, 0, 1);
      expect3("relatch", 1, 1, 0);
      run(0, 0, 0, 12);
      for (int k = 2; k <= 20; k++) begin
         run(0, 1, 0, 12);
         expect3($sformatf("sat%0d", k), 1, (k > 15) ? 4'd15 : 4'(k), 0);
         run(0, 0, 0, 12);
      end
      expect3("sat_final", 1, 15, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, meaning consecutive stable synchronized cycles before the debounced level changes (legal range 2..255).
REQ-002 Parameter STUCK_CYCLES, default 64, meaning continuous debounced-high cycles before the stuck fault is declared (legal range DEBOUNCE_CYCLES+1..65535).
REQ-003 Parameter CNT_W, default 4, meaning width of the pending-arrival counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sensor_raw  input  1  asynchronous, bouncy vehicle-detector contact.
REQ-007 ack  input  1  one-cycle pulse from the traffic-light controller when it grants the sensed approach.
REQ-008 sensor  output  1  registered, clean demand level consumed by the light controller.
REQ-009 pending  output  CNT_W  registered count of arrivals since the last ack, saturating.
REQ-010 fault  output  1  registered stuck-sensor indication.

Function
REQ-011 sensor_raw SHALL pass through a 2-flop synchronizer (sync1, sync2); no other logic SHALL sample sensor_raw.
REQ-012 Debouncer: registered level deb and counter dcnt; when sync2 == deb, dcnt SHALL clear to 0.
REQ-013 When sync2 != deb and dcnt == DEBOUNCE_CYCLES-1, deb SHALL take sync2 and dcnt SHALL clear; otherwise dcnt SHALL increment.
REQ-014 Any cycle where sync2 returns to deb before the threshold SHALL restart the count (glitches shorter than DEBOUNCE_CYCLES cycles are rejected).
REQ-015 Arrival event: a cycle in which deb transitions 0->1; the event SHALL be registered, affecting outputs one edge after deb rises.
REQ-016 Request FSM states IDLE and REQ; sensor SHALL be 1 exactly in REQ or while fault == 1.
REQ-017 IDLE -> REQ on arrival event; REQ -> IDLE on ack with no simultaneous arrival event; REQ holds otherwise.
REQ-018 ack in IDLE SHALL be ignored (no state or counter change).
REQ-019 Simultaneous ack and arrival event: arrival wins; state SHALL be REQ and pending SHALL become 1.
REQ-020 pending SHALL increment by 1 on each arrival event, saturating at 2^CNT_W-1 (no wrap), and clear to 0 on ack (subject to REQ-019).
REQ-021 Total latency: sensor_raw rising and held stable -> sensor high on the (DEBOUNCE_CYCLES+3)th rising edge after the first sampling edge (11 edges at default).
REQ-022 Stuck detector: counter scnt increments (saturating at STUCK_CYCLES) each cycle deb == 1, clears when deb == 0; fault SHALL be 1 when scnt == STUCK_CYCLES.
REQ-023 fault SHALL clear on the edge after deb falls; while fault == 1, sensor SHALL be forced 1 (fail-safe demand) regardless of ack.
REQ-024 Falling deb SHALL NOT clear sensor or pending; only ack (or reset) ends a request.

Reset
REQ-025 When reset == 1 at a rising edge: sync1, sync2, deb, dcnt, scnt SHALL be 0; FSM SHALL be IDLE; sensor = 0, pending = 0, fault = 0 after that edge.
REQ-026 Reset asserted mid-debounce or mid-request SHALL discard all progress; after release a raw level still high SHALL require the full REQ-021 latency to reassert sensor.
REQ-027 Reset SHALL dominate ack and all other inputs in the same cycle.

Verification
REQ-028 Reset, then sensor_raw = 1 held -> sensor = 0 through edge 10, sensor = 1 at edge 11, pending = 1.
REQ-029 sensor_raw pulses high 5 cycles, low 3 cycles, repeated 4 times, then low -> sensor stays 0, pending stays 0.
REQ-030 Three clean arrivals (each high 20, low 20 cycles) with no ack -> sensor = 1, pending = 3; single ack pulse -> sensor = 0, pending = 0 next edge.
REQ-031 ack asserted in the same cycle as the registered arrival event while in REQ with pending = 2 -> state REQ, sensor = 1, pending = 1.
REQ-032 sensor_raw held high 100 cycles -> fault = 1 from 64 cycles after deb rises; ack during fault -> sensor remains 1; raw low -> fault = 0 one edge after deb falls (10 edges after raw falls).
REQ-033 Reset pulsed mid-request with pending = 5 and fault = 1 -> all outputs 0 next edge; 20 arrivals with no ack -> pending saturates at 15.
